// File: rtl/vga_pixel_prefetch_if.sv
// Image ROM read bus: strobe and word address out,
// colour back a fixed number of cycles later.
interface vga_pixel_prefetch_if;
  logic        rom_rd;
  logic [14:0] rom_addr;
  logic [23:0] rom_data;

  modport master (
    output rom_rd,
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_rd,
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/vga_pixel_prefetch.sv
// Raster-order pixel fetcher with power-of-two upscale feeding
// a credit-limited show-ahead colour FIFO for the VGA draw stage.
module vga_pixel_prefetch #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int IMG_W    = 160,
  parameter int SHIFT    = 2,
  parameter int ROM_LAT  = 2,
  parameter int DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    pixel_pop,
  vga_pixel_prefetch_if.master    rom,
  output logic [23:0]             rom_color,
  output logic                    fifo_empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    underflow
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [XW-1:0]      fx;
  logic [XW-1:0]      cur_fx;
  logic [YW-1:0]      fy;
  logic [YW-1:0]      cur_fy;
  logic [14:0]        row_base;
  logic [14:0]        cur_base;
  logic [ROM_LAT-1:0] vsr;
  logic [ROM_LAT-1:0] vsr_n;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt_n;
  logic [23:0]        mem [DEPTH];
  logic [OW-1:0]      pending;
  logic               issue;
  logic               last_px;
  logic               push;
  logic               pop_ok;

  // frame_start issues pixel (0,0) in the same decision cycle
  assign cur_fx   = frame_start ? '0 : fx;
  assign cur_fy   = frame_start ? '0 : fy;
  assign cur_base = frame_start ? '0 : row_base;
  assign last_px  = (cur_fx == XW'(H_ACTIVE - 1)) &&
                    (cur_fy == YW'(V_ACTIVE - 1));

  assign push   = vsr[ROM_LAT-1] & ~frame_start;
  assign pop_ok = pixel_pop & ~fifo_empty & ~frame_start;
  assign cnt_n  = fifo_count + CW'(push) - CW'(pop_ok);

  always_comb begin
    vsr_n    = '0;
    vsr_n[0] = rom.rom_rd;
    for (int i = 1; i < ROM_LAT; i++) begin
      vsr_n[i] = vsr[i-1];
    end
  end

  // every entry already owed to the FIFO, net of this cycle's pop
  always_comb begin
    pending = OW'(fifo_count) + OW'(rom.rom_rd) - OW'(pop_ok);
    for (int i = 0; i < ROM_LAT; i++) begin
      pending = pending + OW'(vsr[i]);
    end
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (1'b1)
      frame_start: begin
        issue   = 1'b1;
        state_n = last_px ? DONE : FETCH;
      end
      (state == FETCH) && !frame_start: begin
        issue = pending < OW'(DEPTH);
        if (issue && last_px) begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fx           <= '0;
      fy           <= '0;
      row_base     <= '0;
      rom.rom_rd   <= 1'b0;
      rom.rom_addr <= '0;
    end else begin
      rom.rom_rd <= issue;
      if (issue) begin
        rom.rom_addr <= cur_base + 15'(cur_fx >> SHIFT);
        if (cur_fx == XW'(H_ACTIVE - 1)) begin
          fx <= '0;
          fy <= cur_fy + YW'(1);
          if (&cur_fy[SHIFT-1:0]) begin
            row_base <= cur_base + 15'(IMG_W);
          end else begin
            row_base <= cur_base;
          end
        end else begin
          fx       <= cur_fx + XW'(1);
          fy       <= cur_fy;
          row_base <= cur_base;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsr        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      underflow  <= 1'b0;
    end else if (frame_start) begin
      vsr        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      underflow  <= 1'b0;
    end else begin
      vsr        <= vsr_n;
      fifo_count <= cnt_n;
      fifo_empty <= (cnt_n == '0);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (pixel_pop && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rom.rom_data;
    end
  end

  assign rom_color = fifo_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Random-pop bench for vga_pixel_prefetch against a raster-order
// pixel-stream model with a latency-L synchronous ROM.
module tb_vga_pixel_prefetch;
  localparam int H    = 640;
  localparam int V    = 8;
  localparam int IW   = 160;
  localparam int S    = 2;
  localparam int L    = 2;
  localparam int D    = 8;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        pixel_pop = 1'b0;
  logic [23:0] rom_color;
  logic        fifo_empty;
  logic [3:0]  fifo_count;
  logic        underflow;
  logic [23:0] pipe [L];

  vga_pixel_prefetch_if bus();

  vga_pixel_prefetch #(
    .H_ACTIVE(H), .V_ACTIVE(V), .IMG_W(IW),
    .SHIFT(S), .ROM_LAT(L), .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .pixel_pop(pixel_pop),
    .rom(bus),
    .rom_color(rom_color),
    .fifo_empty(fifo_empty),
    .fifo_count(fifo_count),
    .underflow(underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [14:0] px_addr(int k);
    int x = k % H;
    int y = k / H;
    return 15'((y >> S) * IW + (x >> S));
  endfunction

  function automatic logic [23:0] rom_fn(logic [14:0] a);
    return {a[7:0] ^ 8'hC3, 1'b0, a};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // synchronous ROM, latency L
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= rom_fn(bus.rom_addr);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rom_data = pipe[L-1];

  // model: expected pixel stream, occupancy, credits, underflow
  int          m_cnt = 0;
  int          m_iss = 0;
  int          m_pop = 0;
  int          acc_pops = 0;
  bit          m_uf = 0;
  bit          m_act = 0;
  bit          m_rd = 0;
  int          arr_q[$];
  logic [14:0] last_addr = '0;
  logic [14:0] line4_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_rd", bus.rom_rd, 0);
      chk("rst_addr", bus.rom_addr, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_color", rom_color, 0);
      chk("rst_uf", underflow, 0);
      m_cnt = 0; m_iss = 0; m_pop = 0; acc_pops = 0;
      m_uf = 0; m_act = 0; m_rd = 0;
      arr_q.delete();
    end else begin : mdl
      int pre;
      chk("rd", bus.rom_rd, m_rd);
      chk("count", fifo_count, m_cnt);
      chk("empty", fifo_empty, m_cnt == 0);
      chk("underflow", underflow, m_uf);
      chk("color", rom_color, m_cnt > 0 ? rom_fn(px_addr(m_pop)) : 24'h0);
      if (bus.rom_rd) begin
        chk("addr", bus.rom_addr, px_addr(m_iss));
        if (m_iss == 4 * H) line4_addr = bus.rom_addr;
        last_addr = bus.rom_addr;
        arr_q.push_back(cyc + L);
        m_iss++;
      end
      if (frame_start) begin
        m_cnt = 0; m_iss = 0; m_pop = 0; acc_pops = 0;
        m_uf = 0; m_act = 1; m_rd = 1;
        arr_q.delete();
      end else begin
        pre = m_cnt;
        if (pixel_pop) begin
          if (pre > 0) begin
            m_pop++; m_cnt--; acc_pops++;
          end else begin
            m_uf = 1;
          end
        end
        while (arr_q.size() > 0 && arr_q[0] == cyc) begin
          void'(arr_q.pop_front());
          m_cnt++;
        end
        m_rd = m_act && (m_iss < NPIX) && ((m_iss - m_pop) < D);
      end
    end
  end

  logic [12:0] rdm;
  logic [14:0] adr [13];

  initial begin
    #2 rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);

    // pop into an empty FIFO while idle
    pixel_pop = 1'b1;
    step(1);
    pixel_pop = 1'b0;
    chk("uf_set", underflow, 1);
    step(3);
    chk("uf_sticky", underflow, 1);
    chk("idle_no_rd", bus.rom_rd, 0);

    // frame start, no pops
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    chk("uf_clear", underflow, 0);
    rdm = '0;
    for (int i = 1; i <= 12; i++) begin
      rdm[i] = bus.rom_rd;
      adr[i] = bus.rom_addr;
      if (i == 3) chk("empty_T3", fifo_empty, 1);
      if (i == 4) chk("empty_T4", fifo_empty, 0);
      if (i == 4) chk("head_T4", rom_color, 24'hC30000);
      step(1);
    end
    chk("rd_window", rdm, 13'b0_0001_1111_1110);
    for (int i = 1; i <= 8; i++)
      chk("burst_addr", adr[i], i <= 4 ? 0 : 1);
    chk("full_count", fifo_count, 8);
    chk("full_head", rom_color, 24'hC30000);

    // full FIFO, pops timed to coincide with refills
    for (int k = 0; k < 8; k++) begin
      pixel_pop = 1'b1;
      step(1);
      pixel_pop = 1'b0;
      for (int j = 0; j < L; j++) begin
        chk("band", (fifo_count >= 7) && (fifo_count <= 8), 1);
        step(1);
      end
    end

    // flush with reads in flight and five entries held
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    for (int k = 0; k < 40 && fifo_count != 5; k++) step(1);
    chk("wait_five", fifo_count, 5);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    chk("flush_count", fifo_count, 0);
    chk("flush_empty", fifo_empty, 1);
    for (int k = 0; k < 40 && fifo_empty; k++) step(1);
    chk("flush_head", rom_color, 24'hC30000);

    // whole frame, popping whenever data is present
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    for (int k = 0; k < 3 * NPIX && acc_pops < NPIX; k++) begin
      pixel_pop = ~fifo_empty;
      step(1);
    end
    pixel_pop = 1'b0;
    step(20);
    chk("frame_pops", acc_pops, NPIX);
    chk("line4_addr", line4_addr, 15'd160);
    chk("last_addr", last_addr, 15'd319);
    chk("frame_uf", underflow, 0);
    chk("done_no_rd", bus.rom_rd, 0);
    chk("done_empty", fifo_empty, 1);

    // whole frame under random pops
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    for (int k = 0; k < 8 * NPIX && acc_pops < NPIX; k++) begin
      pixel_pop = ($urandom_range(0, 99) < 60);
      step(1);
    end
    pixel_pop = 1'b0;
    step(10);
    chk("rand_pops", acc_pops, NPIX);

    // restart mid-frame with random pops around it
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      pixel_pop = ($urandom_range(0, 99) < 40);
      frame_start = (k == 150);
      step(1);
    end
    frame_start = 1'b0;

    // asynchronous reset between edges
    #1 rst = 1'b0;
    #1;
    chk("arst_rd", bus.rom_rd, 0);
    chk("arst_addr", bus.rom_addr, 0);
    chk("arst_empty", fifo_empty, 1);
    chk("arst_count", fifo_count, 0);
    chk("arst_color", rom_color, 0);
    pixel_pop = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    rdm = '0;
    for (int k = 0; k < 10; k++) begin
      rdm[0] = rdm[0] | bus.rom_rd;
      step(1);
    end
    chk("arst_idle", rdm[0], 0);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    chk("restart_rd", bus.rom_rd, 1);
    for (int k = 0; k < 200; k++) begin
      pixel_pop = ($urandom_range(0, 99) < 70);
      step(1);
    end
    pixel_pop = 1'b0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_pixel_prefetch.md
# vga_pixel_prefetch

Upstream feeder for the VGA draw stage. Walks the active frame in raster order and fetches each pixel's 24-bit colour from a synchronous image ROM, scaling a low-resolution image up by a fixed power-of-two factor. Buffers the returned colours in a small show-ahead FIFO. Presents the head entry as `rom_color`, with `fifo_empty` as its status, so the draw stage can consume one pixel per `pixel_pop`.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `IMG_W`, 160: ROM image width in stored pixels; equals H_ACTIVE >> SHIFT.
- `SHIFT`, 2: upscale factor is 2^SHIFT in both axes.
- `ROM_LAT`, 2: cycles from `rom_rd` to valid `rom_data`; legal range 1–4.
- `DEPTH`, 8: FIFO entries; must be a power of two.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `frame_start`  in  1  one-cycle pulse; restarts fetch at pixel (0,0) and flushes the FIFO.
- `pixel_pop`  in  1  draw stage consumes the head entry this cycle.
- `rom_rd`  out  1  ROM read strobe.
- `rom_addr`  out  15  ROM word address; valid while `rom_rd` is high.
- `rom_data`  in  24  ROM colour; valid exactly ROM_LAT cycles after its `rom_rd`.
- `rom_color`  out  24  head FIFO entry, {R,G,B}; 24'h0 while empty.
- `fifo_empty`  out  1  FIFO holds no entries.
- `fifo_count`  out  4  FIFO occupancy, 0..DEPTH.
- `underflow`  out  1  sticky flag; set when `pixel_pop` arrives with the FIFO empty.

## Operation
- States:
  - IDLE: entered from reset; no reads issued.
  - FETCH: issuing reads.
  - DONE: last pixel of the frame issued; no reads.
- Transitions:
  - IDLE/FETCH/DONE -> FETCH on `frame_start`.
  - FETCH -> DONE after issuing the read for (H_ACTIVE-1, V_ACTIVE-1).
- Fetch counters `fx`, `fy` track full-resolution coordinates.
  - After each issued read `fx` increments.
  - At `fx`=H_ACTIVE-1, `fx` wraps to 0 and `fy` increments.
- Address: `rom_addr` = `row_base` + (`fx` >> SHIFT).
  - `row_base` advances by IMG_W whenever `fy` wraps past a multiple of 2^SHIFT.
  - No multiplier is used; `row_base` resets to 0 on `frame_start`.
- Credit rule: a read issues in FETCH only when `fifo_count` + in-flight reads < DEPTH. The FIFO therefore can never overflow.
- Return path: `rom_rd` is delayed through a ROM_LAT-stage valid shift register. When the last stage is valid, `rom_data` is written at `wr_ptr`.
- Pop: `pixel_pop` with `fifo_empty` low advances `rd_ptr`.
  - `pixel_pop` with `fifo_empty` high is ignored and sets `underflow`.
- Simultaneous push and pop with a non-empty FIFO: `fifo_count` is unchanged.
- Simultaneous push and pop with an empty FIFO: the pop is ignored and counts as an underflow; the push completes.
- Flush on `frame_start`:
  - pointers, `fifo_count`, the valid shift register, `fx`, `fy`, `row_base` and `underflow` all clear;
  - ROM data still in flight from before the pulse is discarded;
  - a `pixel_pop` in the same cycle is ignored and does not set `underflow`.
- Reset asserted mid-frame: everything clears immediately; the block stays in IDLE until `frame_start`.

## Timing
- Reset values:
  - `rom_rd`=0, `rom_addr`=0
  - `rom_color`=0
  - `fifo_empty`=1, `fifo_count`=0
  - `underflow`=0
  - state IDLE
- `rom_rd` and `rom_addr` are registered.
- `fifo_empty` and `fifo_count` are registered and reflect the post-edge occupancy.
- `rom_color` is combinational from `mem[rd_ptr]` gated by `fifo_empty`.
- `frame_start` in cycle T:
  - first `rom_rd` (addr 0) in cycle T+1;
  - data written at the end of cycle T+1+ROM_LAT;
  - `fifo_empty` low in cycle T+2+ROM_LAT (T+4 at defaults).
- Peak issue rate is one read per cycle.
- With no pops, `rom_rd` is high for exactly DEPTH consecutive cycles (T+1..T+8), then stays low.
- Each accepted pop frees one credit: `rom_rd` may reassert in the cycle after the pop edge.
- Pop-to-new-head latency is 0: the next entry is visible on `rom_color` in the cycle after the pop edge.

## Test plan
- Reset then `frame_start`, no pops, ROM returns data equal to its address:
  - `rom_rd` high in cycles T+1..T+8 with addresses 0,0,0,0,1,1,1,1;
  - `fifo_count` reaches 8;
  - `rom_color`=24'h000000 at the head.
- Continuous `pixel_pop` whenever `fifo_empty` is low, over a full frame:
  - 307200 pops accepted;
  - address sequence repeats each group of 4 lines;
  - line 4 begins at address 160; final address 19199;
  - state ends in DONE; `underflow` stays 0.
- `pixel_pop` held high from T with the FIFO empty:
  - `underflow`=1 from T+1;
  - it stays set until the next `frame_start`.
- `frame_start` reasserted while 2 reads are in flight and the FIFO holds 5 entries:
  - next cycle `fifo_count`=0 and `fifo_empty`=1;
  - the stale returns are not written;
  - the next head entry is from address 0.
- Full FIFO, then a push and a pop in the same cycle:
  - `fifo_count` stays at DEPTH-1 to DEPTH with no overflow;
  - ordering of `rom_color` values is preserved.
- `rst` driven low mid-frame, asynchronously between edges:
  - outputs go to their reset values immediately;
  - no `rom_rd` occurs until `frame_start`.
